// File: rtl/adder_pkg.sv
// Shared constants and result type for the structural ripple adder.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 4;

  // Carry sits above the sum so {carry_out, sum} packs straight into this.
  typedef struct packed {
    logic                           carry;
    logic [ADDER_DEFAULT_WIDTH-1:0] sum;
  } adder_result_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full-adder cell; the ripple chain is built from these.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign sum    = w_prop ^ cin;
  assign cout   = (a & b) | (cin & w_prop);

endmodule

// File: rtl/ripple_adder_4bit_structural.sv
// Structural WIDTH-bit ripple-carry adder with a one-cycle registered copy.
// Define RIPPLE_ADDER_OVERFLOW_FLAG_EN to add signed overflow / overflow_q.
module ripple_adder_4bit_structural
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             out_valid
`ifdef RIPPLE_ADDER_OVERFLOW_FLAG_EN
  ,
  output logic             overflow,
  output logic             overflow_q
`endif
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = carry_in;

  // Each cell takes its carry from the one below; no behavioural add anywhere.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_1bit u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (w_carry[gi]),
      .sum  (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  assign sum       = w_sum;
  assign carry_out = w_carry[WIDTH];

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry[WIDTH];
      end
    end
  end

  assign sum_q       = r_sum;
  assign carry_out_q = r_carry;
  assign out_valid   = r_valid;

`ifdef RIPPLE_ADDER_OVERFLOW_FLAG_EN
  logic w_overflow;
  logic r_overflow;

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (in_valid) begin
      r_overflow <= w_overflow;
    end
  end

  assign overflow   = w_overflow;
  assign overflow_q = r_overflow;
`endif

endmodule

// File: tb/tb_ripple_adder_4bit_structural.sv
// Scoreboard bench for ripple_adder_4bit_structural: directed vectors,
// reset behaviour and a full 512-combination sweep.
module tb_ripple_adder_4bit_structural;
  import adder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       carry_in;
  logic       in_valid;
  logic [3:0] sum;
  logic       carry_out;
  logic [3:0] sum_q;
  logic       carry_out_q;
  logic       out_valid;
`ifdef RIPPLE_ADDER_OVERFLOW_FLAG_EN
  logic       overflow;
  logic       overflow_q;
`endif

  int checks = 0;
  int errors = 0;
  adder_result_t sb[$];

  ripple_adder_4bit_structural #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .in_valid    (in_valid),
    .sum         (sum),
    .carry_out   (carry_out),
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q),
    .out_valid   (out_valid)
`ifdef RIPPLE_ADDER_OVERFLOW_FLAG_EN
    ,
    .overflow    (overflow),
    .overflow_q  (overflow_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors {a, b, carry_in, expected sum, expected carry_out}.
  localparam logic [13:0] VECS [8] = '{
    {4'd0,  4'd0,  1'b0, 4'd0,  1'b0},
    {4'd0,  4'd0,  1'b1, 4'd1,  1'b0},
    {4'd1,  4'd1,  1'b0, 4'd2,  1'b0},
    {4'd1,  4'd1,  1'b1, 4'd3,  1'b0},
    {4'd3,  4'd6,  1'b0, 4'd9,  1'b0},
    {4'd15, 4'd1,  1'b0, 4'd0,  1'b1},
    {4'd15, 4'd15, 1'b1, 4'd15, 1'b1},
    {4'd7,  4'd8,  1'b1, 4'd0,  1'b1}
  };

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Drive on the falling edge, check the combinational result 1 time unit later,
  // and queue the registered expectation if this cycle will be captured.
  task automatic apply(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                       input logic tv, input logic [3:0] es, input logic ec);
    @(negedge clk);
    a = ta; b = tb_; carry_in = tc; in_valid = tv;
    #1;
    check("comb_sum", {4'd0, sum}, {4'd0, es});
    check("comb_carry", {7'd0, carry_out}, {7'd0, ec});
    if (tv && rst_n) sb.push_back('{carry: ec, sum: es});
    $display("txn a=%0d b=%0d cin=%0d valid=%0d sum=%0d cout=%0d", ta, tb_, tc, tv, sum, carry_out);
  endtask

  // Monitor: whenever the register stage presents a result, compare against the queue.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      adder_result_t got;
      adder_result_t exp;
      got = {carry_out_q, sum_q};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%0h expected=no pending result", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_result got=%0h expected=%0h", got, exp);
        end
      end
    end
  end

  initial begin
    logic [13:0] v;
    logic [4:0]  e;
    rst_n = 1'b0; a = '0; b = '0; carry_in = 1'b0; in_valid = 1'b1;

    // Combinational path is live during reset; registers stay cleared.
    apply(4'd3, 4'd6, 1'b0, 1'b1, 4'd9, 1'b0);
    @(negedge clk); #1;
    check("rst_sum_q", {4'd0, sum_q}, 8'd0);
    check("rst_carry_q", {7'd0, carry_out_q}, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // One capture, then a hold cycle.
    apply(4'd3, 4'd6, 1'b0, 1'b1, 4'd9, 1'b0);
    apply(4'd1, 4'd2, 1'b0, 1'b0, 4'd3, 1'b0);
    @(posedge clk); #2;
    check("hold_out_valid", {7'd0, out_valid}, 8'd0);
    check("hold_sum_q", {4'd0, sum_q}, 8'd9);

    for (int i = 0; i < 8; i++) begin
      v = VECS[i];
      apply(v[13:10], v[9:6], v[5], 1'b1, v[4:1], v[0]);
    end

`ifdef RIPPLE_ADDER_OVERFLOW_FLAG_EN
    apply(4'd7, 4'd1, 1'b0, 1'b1, 4'd8, 1'b0);
    check("ovf_7_1", {7'd0, overflow}, 8'd1);
    apply(4'd3, 4'd2, 1'b0, 1'b1, 4'd5, 1'b0);
    check("ovf_3_2", {7'd0, overflow}, 8'd0);
    apply(4'd8, 4'd8, 1'b0, 1'b1, 4'd0, 1'b1);
    check("ovf_8_8", {7'd0, overflow}, 8'd1);
    @(posedge clk); #2;
    check("ovf_q_8_8", {7'd0, overflow_q}, 8'd1);
`endif

    // Asynchronous reset mid-stream: capture 10, then clear between edges.
    apply(4'd5, 4'd5, 1'b0, 1'b1, 4'd10, 1'b0);
    @(posedge clk); #2;
    check("pre_rst_sum_q", {4'd0, sum_q}, 8'd10);
    rst_n = 1'b0;
    #1;
    check("async_rst_sum_q", {4'd0, sum_q}, 8'd0);
    check("async_rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("async_rst_comb_sum", {4'd0, sum}, 8'd10);
    apply(4'd2, 4'd2, 1'b0, 1'b1, 4'd4, 1'b0);
    apply(4'd2, 4'd3, 1'b0, 1'b1, 4'd5, 1'b0);
    @(posedge clk); #2;
    check("in_rst_out_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Exhaustive sweep, back-to-back captures.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          e = 5'(ia) + 5'(ib) + 5'(ic);
          apply(4'(ia), 4'(ib), 1'(ic), 1'b1, e[3:0], e[4]);
        end
      end
    end

    apply(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
